// File: rtl/ntt_pkg.sv
// Shared types and constants for the NTT core scheduler slice.
package ntt_pkg;

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StGrant   = 3'd1,
    StRun     = 3'd2,
    StRelease = 3'd3
  } ntt_state_e;

  localparam int unsigned DefaultNumReq  = 4;
  localparam int unsigned DefaultTimeout = 1024;

  localparam int unsigned NttN     = 256;
  localparam int unsigned NttQ     = 3329;
  localparam int unsigned NttCoefW = 12;

  typedef logic [NttCoefW-1:0] ntt_coef_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: the first set request at or after ptr_i, wrapping.
module rr_arbiter #(
  parameter int unsigned NumReq = 4
) (
  input  logic [NumReq-1:0]         req_i,
  input  logic [$clog2(NumReq)-1:0] ptr_i,
  output logic                      valid_o,
  output logic [$clog2(NumReq)-1:0] idx_o
);

  localparam int unsigned IdxW = $clog2(NumReq);

  int unsigned cand;

  // Walk offsets from farthest to nearest so the candidate closest to ptr_i wins.
  always_comb begin
    valid_o = |req_i;
    idx_o   = '0;
    cand    = 0;
    for (int unsigned off = NumReq; off > 0; off--) begin
      cand = 32'(ptr_i) + off - 1;
      if (cand >= NumReq) begin
        cand = cand - NumReq;
      end
      if (req_i[IdxW'(cand)]) begin
        idx_o = IdxW'(cand);
      end
    end
  end

endmodule

// File: rtl/ntt_sched.sv
// Round-robin scheduler sharing one NTT core between NUM_REQ requesters, with
// withdrawal and timeout abort; every output comes straight from a flop.
module ntt_sched
  import ntt_pkg::*;
#(
  parameter int unsigned NUM_REQ = DefaultNumReq,
  parameter int unsigned TIMEOUT = DefaultTimeout
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic [NUM_REQ-1:0]         req_i,
  output logic [NUM_REQ-1:0]         gnt_o,
  output logic [$clog2(NUM_REQ)-1:0] sel_o,
  output logic [NUM_REQ-1:0]         done_o,
  output logic                       err_o,
  output logic                       busy_o,
  output logic                       ntt_start_o,
  input  logic                       ntt_done_i
);

  localparam int unsigned IdxW   = $clog2(NUM_REQ);
  localparam int unsigned TimerW = $clog2(TIMEOUT);

  ntt_state_e          state_q, state_d;
  logic [IdxW-1:0]     ptr_q, ptr_d;
  logic [IdxW-1:0]     sel_q, sel_d;
  logic [TimerW-1:0]   timer_q, timer_d;
  logic [NUM_REQ-1:0]  gnt_q, gnt_d;
  logic [NUM_REQ-1:0]  done_q, done_d;
  logic                err_q, err_d;
  logic                busy_q, busy_d;
  logic                start_q, start_d;

  logic                arb_valid;
  logic [IdxW-1:0]     arb_idx;
  logic                leave_run;
  logic [IdxW-1:0]     next_ptr;

  rr_arbiter #(
    .NumReq(NUM_REQ)
  ) u_arb (
    .req_i  (req_i),
    .ptr_i  (ptr_q),
    .valid_o(arb_valid),
    .idx_o  (arb_idx)
  );

  assign next_ptr = (sel_q == IdxW'(NUM_REQ - 1)) ? '0 : sel_q + IdxW'(1);

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    sel_d     = sel_q;
    timer_d   = timer_q;
    gnt_d     = gnt_q;
    done_d    = '0;
    err_d     = 1'b0;
    start_d   = start_q;
    leave_run = 1'b0;

    case (state_q)
      StIdle: begin
        gnt_d   = '0;
        start_d = 1'b0;
        if (arb_valid) begin
          state_d        = StGrant;
          sel_d          = arb_idx;
          gnt_d[arb_idx] = 1'b1;
          timer_d        = '0;
        end
      end

      // One dead cycle so the coefficient mux follows sel_o before the core starts.
      StGrant: begin
        state_d = StRun;
        start_d = 1'b1;
      end

      // Completion beats withdrawal, which beats timeout.
      StRun: begin
        if (ntt_done_i) begin
          done_d[sel_q] = 1'b1;
          leave_run     = 1'b1;
        end else if (!req_i[sel_q]) begin
          leave_run = 1'b1;
        end else if (timer_q == TimerW'(TIMEOUT - 1)) begin
          err_d     = 1'b1;
          leave_run = 1'b1;
        end else begin
          timer_d = timer_q + TimerW'(1);
        end
        if (leave_run) begin
          state_d = StRelease;
          start_d = 1'b0;
          gnt_d   = '0;
          ptr_d   = next_ptr;
        end
      end

      // Hold off until the core has seen start drop and lowered its done.
      StRelease: begin
        start_d = 1'b0;
        gnt_d   = '0;
        if (!ntt_done_i) begin
          state_d = StIdle;
        end
      end

      default: begin
        state_d = StIdle;
        gnt_d   = '0;
        start_d = 1'b0;
      end
    endcase

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      sel_q   <= '0;
      timer_q <= '0;
      gnt_q   <= '0;
      done_q  <= '0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      timer_q <= timer_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      start_q <= start_d;
    end
  end

  assign gnt_o       = gnt_q;
  assign sel_o       = sel_q;
  assign done_o      = done_q;
  assign err_o       = err_q;
  assign busy_o      = busy_q;
  assign ntt_start_o = start_q;

endmodule

// File: tb/tb_ntt_sched.sv
// Scoreboard bench for ntt_sched: two instances (default timeout and TIMEOUT=16),
// job-level reference model predicting output events and their cycle numbers.
module tb_ntt_sched;

  localparam int NumU  = 2;
  localparam int To0   = 1024;
  localparam int To1   = 16;
  localparam int Never = 100000;

  typedef enum int {
    EvGnt, EvSel, EvBusyRise, EvStart, EvDone, EvErr, EvStop, EvGntFall, EvBusyFall
  } ev_e;

  typedef struct {
    int         uid;
    ev_e        kind;
    logic [3:0] val;
    int         cyc;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst_ni = 1'b1;
  logic [3:0] req       [NumU];
  logic       core_done [NumU];
  logic [3:0] gnt       [NumU];
  logic [1:0] sel       [NumU];
  logic [3:0] dn        [NumU];
  logic       err       [NumU];
  logic       busy      [NumU];
  logic       start     [NumU];

  logic [3:0] prev_gnt   [NumU];
  logic       prev_busy  [NumU];
  logic       prev_start [NumU];

  ev_t exp_q[$];
  int  mptr [NumU];
  int  cyc = 0;
  int  n_checks = 0;
  int  n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ntt_sched #(.NUM_REQ(4), .TIMEOUT(To0)) u_dut0 (
    .clk_i      (clk),
    .rst_ni     (rst_ni),
    .req_i      (req[0]),
    .gnt_o      (gnt[0]),
    .sel_o      (sel[0]),
    .done_o     (dn[0]),
    .err_o      (err[0]),
    .busy_o     (busy[0]),
    .ntt_start_o(start[0]),
    .ntt_done_i (core_done[0])
  );

  ntt_sched #(.NUM_REQ(4), .TIMEOUT(To1)) u_dut1 (
    .clk_i      (clk),
    .rst_ni     (rst_ni),
    .req_i      (req[1]),
    .gnt_o      (gnt[1]),
    .sel_o      (sel[1]),
    .done_o     (dn[1]),
    .err_o      (err[1]),
    .busy_o     (busy[1]),
    .ntt_start_o(start[1]),
    .ntt_done_i (core_done[1])
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  task automatic push(input int u, input ev_e k, input logic [3:0] v, input int cy);
    ev_t e;
    e.uid  = u;
    e.kind = k;
    e.val  = v;
    e.cyc  = cy;
    exp_q.push_back(e);
  endtask

  task automatic observe(input int u, input ev_e k, input logic [3:0] v);
    ev_t e;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL event: got unit%0d %s val=%0h cyc=%0d, required nothing", u, k.name(), v,
               cyc);
    end else begin
      e = exp_q.pop_front();
      if (e.uid != u || e.kind != k || e.val !== v || e.cyc != cyc) begin
        n_fail++;
        $display("FAIL event: got unit%0d %s val=%0h cyc=%0d, required unit%0d %s val=%0h cyc=%0d",
                 u, k.name(), v, cyc, e.uid, e.kind.name(), e.val, e.cyc);
      end
    end
  endtask

  // Turns output edges into events, in a fixed per-cycle order the driver mirrors.
  task automatic mon_unit(input int u);
    if (gnt[u] != '0 && prev_gnt[u] == '0) begin
      observe(u, EvGnt, gnt[u]);
      observe(u, EvSel, {2'b00, sel[u]});
    end
    if (busy[u] && !prev_busy[u]) observe(u, EvBusyRise, '0);
    if (start[u] && !prev_start[u]) observe(u, EvStart, '0);
    if (dn[u] != '0) observe(u, EvDone, dn[u]);
    if (err[u]) observe(u, EvErr, 4'd1);
    if (!start[u] && prev_start[u]) observe(u, EvStop, '0);
    if (gnt[u] == '0 && prev_gnt[u] != '0) observe(u, EvGntFall, '0);
    if (!busy[u] && prev_busy[u]) observe(u, EvBusyFall, '0);
    chk("gnt_onehot", 32'($onehot0(gnt[u])), 32'd1);
    chk("done_onehot", 32'($onehot0(dn[u])), 32'd1);
    if (gnt[u] != '0 && prev_gnt[u] != '0) chk("gnt_stable", gnt[u], prev_gnt[u]);
  endtask

  always @(negedge clk) begin
    if (rst_ni) begin
      mon_unit(0);
      mon_unit(1);
    end
    prev_gnt   <= gnt;
    prev_busy  <= busy;
    prev_start <= start;
  end

  function automatic int rr_pick(input logic [3:0] v, input int p);
    for (int i = 0; i < 4; i++) begin
      if (v[(p + i) % 4]) return (p + i) % 4;
    end
    return -1;
  endfunction

  task automatic mid_reset(input int u);
    #2 rst_ni = 1'b0;
    #1;
    chk("rst_mid_start", start[u], 0);
    chk("rst_mid_gnt", gnt[u], 0);
    chk("rst_mid_sel", sel[u], 0);
    chk("rst_mid_busy", busy[u], 0);
    chk("rst_mid_done", dn[u], 0);
    chk("rst_mid_err", err[u], 0);
    req[u]       = '0;
    core_done[u] = 1'b0;
    @(negedge clk);
    chk("rst_mid_queue", exp_q.size(), 0);
    #2 rst_ni = 1'b1;
    mptr[0] = 0;
    mptr[1] = 0;
  endtask

  // One job: core raises done d RUN cycles in, owner withdraws w cycles in; the
  // first of done/withdraw/timeout (ties broken in that order) ends it.
  task automatic run_job(input int u, input logic [3:0] vec, input int d, input int w,
                         input int r, input bit jitter, input int rst_at);
    int c, owner, m, e, hold, to;
    logic [3:0] cur;
    to = (u == 0) ? To0 : To1;
    @(negedge clk);
    c     = cyc;
    owner = rr_pick(vec, mptr[u]);
    m     = to - 1;
    if (w < m) m = w;
    if (d < m) m = d;
    e    = c + 3 + m;
    hold = (d == m) ? r : 0;
    push(u, EvGnt, 4'(1 << owner), c + 1);
    push(u, EvSel, 4'(owner), c + 1);
    push(u, EvBusyRise, '0, c + 1);
    push(u, EvStart, '0, c + 2);
    if (rst_at < 0) begin
      if (d == m) push(u, EvDone, 4'(1 << owner), e);
      else if (w != m) push(u, EvErr, 4'd1, e);
      push(u, EvStop, '0, e);
      push(u, EvGntFall, '0, e);
      push(u, EvBusyFall, '0, e + hold + 1);
      mptr[u] = (owner + 1) % 4;
    end
    req[u]       = vec;
    core_done[u] = 1'b0;
    @(negedge clk);
    if (jitter) begin
      cur        = 4'($urandom);
      cur[owner] = 1'b1;
      req[u]     = cur;
    end
    for (int j = 0; j <= m; j++) begin
      @(negedge clk);
      if (j == rst_at) begin
        mid_reset(u);
        return;
      end
      cur          = jitter ? 4'($urandom) : req[u];
      cur[owner]   = (j < w);
      req[u]       = cur;
      core_done[u] = (j >= d);
    end
    @(negedge clk);
    repeat (hold) @(negedge clk);
    core_done[u] = 1'b0;
    req[u]       = '0;
  endtask

  initial begin
    repeat (60000) @(posedge clk);
    n_fail++;
    $display("FAIL watchdog: got cycle %0d, required finish earlier", cyc);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int u = 0; u < NumU; u++) begin
      req[u]        = '0;
      core_done[u]  = 1'b0;
      mptr[u]       = 0;
      prev_gnt[u]   = '0;
      prev_busy[u]  = 1'b0;
      prev_start[u] = 1'b0;
    end
    #1 rst_ni = 1'b0;
    #1;
    for (int u = 0; u < NumU; u++) begin
      chk("rst_gnt", gnt[u], 0);
      chk("rst_sel", sel[u], 0);
      chk("rst_done", dn[u], 0);
      chk("rst_err", err[u], 0);
      chk("rst_busy", busy[u], 0);
      chk("rst_start", start[u], 0);
    end
    repeat (3) @(negedge clk);
    #2 rst_ni = 1'b1;

    // Everyone requesting from ptr=0: owners 0,1,2,3,0.
    for (int n = 0; n < 5; n++) begin
      run_job(0, 4'hF, int'($urandom_range(0, 20)), Never, int'($urandom_range(0, 2)), 1'b0,
              -1);
    end
    // Lone requester, core finishes 200 cycles after start.
    run_job(0, 4'b0001, 200, Never, 2, 1'b0, -1);
    // Requester 2 withdraws 50 cycles into RUN; then 3 is next in line.
    run_job(0, 4'b0100, Never, 50, 0, 1'b0, -1);
    run_job(0, 4'hF, 5, Never, 1, 1'b0, -1);
    // Short-timeout instance: core never finishes, then the next requester is served.
    run_job(1, 4'b0011, Never, Never, 0, 1'b0, -1);
    run_job(1, 4'b0011, 3, Never, 0, 1'b0, -1);
    // Done, withdrawal and timer expiry all at the same edge.
    run_job(1, 4'b1000, To1 - 1, To1 - 1, 1, 1'b0, -1);

    for (int n = 0; n < 40; n++) begin
      int u, d, w;
      u = n % 2;
      d = int'($urandom_range(0, 40));
      w = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 40)) : Never;
      run_job(u, 4'($urandom_range(1, 15)), d, w, int'($urandom_range(0, 3)), 1'b1, -1);
    end

    // Reset in the middle of a job, then both instances restart from ptr=0.
    run_job(0, 4'b0100, Never, Never, 0, 1'b0, 30);
    run_job(0, 4'hF, 4, Never, 0, 1'b0, -1);
    run_job(1, 4'hF, 2, Never, 0, 1'b0, -1);

    repeat (4) @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
